// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and helpers for the program-counter unit.
package pc_unit_pkg;

    // Fetch-sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStall
    } pc_state_e;

    // Default PC loaded on reset.
    localparam int unsigned PC_RESET_ADDR_DFLT = 0;

    // log2 of a power-of-two instruction size; used as the offset scaling shift.
    function automatic int unsigned instr_shift(input int unsigned bytes);
        int unsigned sh;
        sh = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) == bytes) begin
                sh = i;
            end
        end
        return sh;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop on an empty stack is ignored.
module pc_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         PUSH,
    input  logic         POP,
    input  logic [W-1:0] PUSH_DATA,
    output logic [W-1:0] TOP,
    output logic         EMPTY,
    output logic         FULL
);
    localparam int unsigned    PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // wr_ptr_q is the next slot to write; the top entry sits just below it.
    assign top_ptr = (wr_ptr_q == '0) ? LAST : wr_ptr_q - PTR_W'(1);
    assign TOP     = mem_q[top_ptr];
    assign EMPTY   = (cnt_q == '0);
    assign FULL    = (cnt_q == CNT_W'(DEPTH));

    // Pointer and occupancy next state; the count saturates when overwriting.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (PUSH) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (!FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (POP && !EMPTY) begin
            wr_ptr_d = top_ptr;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (PUSH) begin
            mem_q[wr_ptr_q] <= PUSH_DATA;
        end
    end

endmodule

// File: rtl/pc_unit_gen.sv
// pc_unit_gen: parametrised program-counter unit with fetch FSM, instruction-memory
// stall handshake, beq/bne/jump redirect, saturating retired-instruction counter and
// sticky illegal-control flag. Defining PC_UNIT_RAS_EN adds CALL/RET ports and a
// return-address stack (pc_ras).
module pc_unit_gen
    import pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       OFFSET_W    = 8,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR_DFLT),
    parameter int unsigned       CNT_W       = 16,
    parameter int unsigned       RAS_DEPTH   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic                JUMP,
    input  logic                BRANCH,
    input  logic                BRANCH_NE,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET,
`ifdef PC_UNIT_RAS_EN
    input  logic                CALL,
    input  logic                RET,
`endif
    output logic [ADDR_W-1:0]   PC,
    output logic                PC_VALID,
    output logic [ADDR_W-1:0]   PC_SEQ,
    output logic                TAKEN,
    output logic [CNT_W-1:0]    RETIRED,
    output logic                CTRL_ERR
);
    localparam int unsigned SHIFT = instr_shift(INSTR_BYTES);
`ifdef PC_UNIT_RAS_EN
    localparam int unsigned N_CTRL = 5;
`else
    localparam int unsigned N_CTRL = 3;
`endif

    if ((32'd1 << SHIFT) != INSTR_BYTES) begin : g_bad_instr_bytes
        $error("INSTR_BYTES must be a power of two");
    end
    if (RAS_DEPTH == 0) begin : g_bad_ras_depth
        $error("RAS_DEPTH must be at least 1");
    end

    pc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  seq, target, off_ext, next_pc;
    logic [N_CTRL-1:0]  ctrl_vec;
    logic               pc_valid, advance, illegal, taken_raw, ret_err;

`ifdef PC_UNIT_RAS_EN
    logic               ras_push, ras_pop, ras_empty, ras_full;
    logic [ADDR_W-1:0]  ras_top;

    assign ctrl_vec = {JUMP, BRANCH, BRANCH_NE, CALL, RET};

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .CLK       (CLK),
        .RESET     (RESET),
        .PUSH      (ras_push),
        .POP       (ras_pop),
        .PUSH_DATA (seq),
        .TOP       (ras_top),
        .EMPTY     (ras_empty),
        .FULL      (ras_full)
    );
`else
    assign ctrl_vec = {JUMP, BRANCH, BRANCH_NE};
`endif

    assign pc_valid = (state_q != StIdle);
    assign advance  = pc_valid && !BUSYWAIT;
    assign illegal  = ($countones(ctrl_vec) > 1);
    assign seq      = pc_q + ADDR_W'(INSTR_BYTES);
    assign off_ext  = ADDR_W'($signed(OFFSET));
    assign target   = seq + (off_ext << SHIFT);

    // Redirect decode; an illegal combination falls through to the sequential PC.
    always_comb begin
        taken_raw = 1'b0;
        ret_err   = 1'b0;
        next_pc   = seq;
`ifdef PC_UNIT_RAS_EN
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
`endif
        if (!illegal) begin
            if (JUMP || (BRANCH && ZERO) || (BRANCH_NE && !ZERO)) begin
                taken_raw = 1'b1;
                next_pc   = target;
            end
`ifdef PC_UNIT_RAS_EN
            if (CALL) begin
                taken_raw = 1'b1;
                next_pc   = target;
                ras_push  = advance;
            end
            if (RET) begin
                if (ras_empty) begin
                    ret_err = 1'b1;
                end else begin
                    taken_raw = 1'b1;
                    next_pc   = ras_top;
                    ras_pop   = advance;
                end
            end
`endif
        end
    end

    // Fetch FSM next state plus PC/counter/flag updates on retiring edges.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        err_d     = err_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (BUSYWAIT) state_d = StStall;
            StStall: if (!BUSYWAIT) state_d = StFetch;
            default: state_d = StIdle;
        endcase
        if (advance) begin
            pc_d = next_pc;
            if (retired_q != '1) begin
                retired_d = retired_q + CNT_W'(1);
            end
            if (illegal || ret_err) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset wins over every other condition, including a stall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            pc_q      <= RESET_ADDR;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign PC       = pc_q;
    assign PC_VALID = pc_valid;
    assign PC_SEQ   = pc_valid ? seq : '0;
    assign TAKEN    = pc_valid && taken_raw;
    assign RETIRED  = retired_q;
    assign CTRL_ERR = err_q;

endmodule

// File: tb/tb_pc_unit_gen.sv
// tb_pc_unit_gen: drives a 32-bit instance and an 8-bit/4-bit-counter instance with
// the same stimulus and compares both against a behavioural reference model.
module tb_pc_unit_gen;
    localparam int RAS_D = 4;

    logic        CLK, RESET, BUSYWAIT, JUMP, BRANCH, BRANCH_NE, ZERO;
    logic [7:0]  OFFSET;
`ifdef PC_UNIT_RAS_EN
    logic        CALL, RET;
`endif

    logic [31:0] pc_a, seq_a;
    logic        pv_a, tk_a, err_a;
    logic [15:0] ret_a;
    logic [7:0]  pc_b, seq_b;
    logic        pv_b, tk_b, err_b;
    logic [3:0]  ret_b;

    logic [64:0] obs_st;
    logic [41:0] obs_cb;
    assign obs_st = {pv_a, err_a, ret_a, pc_a, pv_b, err_b, ret_b, pc_b};
    assign obs_cb = {tk_a, seq_a, tk_b, seq_b};

    // Reference model: index 0 is the 32-bit instance, index 1 the 8-bit one.
    longint m_pc [2];
    int     m_ret [2];
    bit     m_err [2];
    bit     m_valid;
    longint mask [2]    = '{64'hFFFF_FFFF, 64'hFF};
    int     cnt_max [2] = '{65535, 15};
    longint rst_pc [2]  = '{0, 64'hF4};
    int     n_tests, n_fail;
`ifdef PC_UNIT_RAS_EN
    longint ras0[$];
    longint ras1[$];
`endif

    pc_unit_gen #(
        .ADDR_W(32), .OFFSET_W(8), .INSTR_BYTES(4), .RESET_ADDR(32'h0),
        .CNT_W(16), .RAS_DEPTH(RAS_D)
    ) u_a (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
        .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .OFFSET(OFFSET),
`ifdef PC_UNIT_RAS_EN
        .CALL(CALL), .RET(RET),
`endif
        .PC(pc_a), .PC_VALID(pv_a), .PC_SEQ(seq_a), .TAKEN(tk_a), .RETIRED(ret_a),
        .CTRL_ERR(err_a)
    );

    pc_unit_gen #(
        .ADDR_W(8), .OFFSET_W(8), .INSTR_BYTES(4), .RESET_ADDR(8'hF4),
        .CNT_W(4), .RAS_DEPTH(RAS_D)
    ) u_b (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
        .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .OFFSET(OFFSET),
`ifdef PC_UNIT_RAS_EN
        .CALL(CALL), .RET(RET),
`endif
        .PC(pc_b), .PC_VALID(pv_b), .PC_SEQ(seq_b), .TAKEN(tk_b), .RETIRED(ret_b),
        .CTRL_ERR(err_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef PC_UNIT_RAS_EN
    function automatic int ras_size(input int k);
        return (k == 0) ? ras0.size() : ras1.size();
    endfunction

    function automatic void ras_push(input int k, input longint v);
        if (k == 0) begin
            if (ras0.size() == RAS_D) void'(ras0.pop_front());
            ras0.push_back(v);
        end else begin
            if (ras1.size() == RAS_D) void'(ras1.pop_front());
            ras1.push_back(v);
        end
    endfunction

    function automatic longint ras_pop(input int k);
        return (k == 0) ? ras0.pop_back() : ras1.pop_back();
    endfunction
`endif

    function automatic int n_ctrl();
        int n;
        n = int'(JUMP) + int'(BRANCH) + int'(BRANCH_NE);
`ifdef PC_UNIT_RAS_EN
        n += int'(CALL) + int'(RET);
`endif
        return n;
    endfunction

    function automatic bit exp_taken(input int k);
        if (!m_valid || n_ctrl() > 1) return 1'b0;
        if (JUMP || (BRANCH && ZERO) || (BRANCH_NE && !ZERO)) return 1'b1;
`ifdef PC_UNIT_RAS_EN
        if (CALL) return 1'b1;
        if (RET) return ras_size(k) > 0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [64:0] exp_st();
        longint pa, pb;
        int     ra, rb;
        pa = m_pc[0];
        pb = m_pc[1];
        ra = m_ret[0];
        rb = m_ret[1];
        return {m_valid, m_err[0], ra[15:0], pa[31:0], m_valid, m_err[1], rb[3:0], pb[7:0]};
    endfunction

    function automatic logic [41:0] exp_cb();
        longint sa, sb;
        sa = m_valid ? ((m_pc[0] + 4) & mask[0]) : 0;
        sb = m_valid ? ((m_pc[1] + 4) & mask[1]) : 0;
        return {exp_taken(0), sa[31:0], exp_taken(1), sb[7:0]};
    endfunction

    // Advance one clock and apply the specified edge behaviour to the model.
    task automatic tick();
        longint off, seq, tgt, nxt;
        bit     bad;
        @(posedge CLK);
        off = longint'($signed(OFFSET));
        if (RESET) begin
            m_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_pc[k]  = rst_pc[k];
                m_ret[k] = 0;
                m_err[k] = 1'b0;
            end
`ifdef PC_UNIT_RAS_EN
            ras0.delete();
            ras1.delete();
`endif
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (!BUSYWAIT) begin
            for (int k = 0; k < 2; k++) begin
                seq = (m_pc[k] + 4) & mask[k];
                tgt = (seq + off * 4) & mask[k];
                nxt = seq;
                bad = (n_ctrl() > 1);
                if (!bad) begin
                    if (JUMP || (BRANCH && ZERO) || (BRANCH_NE && !ZERO)) nxt = tgt;
`ifdef PC_UNIT_RAS_EN
                    if (CALL) begin
                        nxt = tgt;
                        ras_push(k, seq);
                    end
                    if (RET) begin
                        if (ras_size(k) == 0) bad = 1'b1;
                        else nxt = ras_pop(k);
                    end
`endif
                end
                if (bad) m_err[k] = 1'b1;
                m_pc[k] = nxt;
                if (m_ret[k] < cnt_max[k]) m_ret[k]++;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        BUSYWAIT  = 1'b0;
        JUMP      = 1'b0;
        BRANCH    = 1'b0;
        BRANCH_NE = 1'b0;
        ZERO      = 1'b0;
        OFFSET    = 8'h00;
`ifdef PC_UNIT_RAS_EN
        CALL = 1'b0;
        RET  = 1'b0;
`endif
    endtask

    // Reset, then n plain edges; restart(3) leaves the 32-bit PC at 8.
    task automatic restart(input int n);
        idle_inputs();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET    = 1'b1;
        BUSYWAIT = 1'($urandom);
        JUMP     = 1'b1;
        ZERO     = 1'($urandom);
        OFFSET   = 8'($urandom);
        tick();
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd0 || pv_a !== 1'b0 || ret_a !== 16'd0
            || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs_st, exp_st());
        end
        n_tests++;
        if (obs_cb !== exp_cb() || tk_a !== 1'b0 || seq_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: got %h want %h", obs_cb, exp_cb());
        end
        RESET = 1'b0;
        idle_inputs();
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pv_a !== 1'b1 || pc_a !== 32'd0 || ret_a !== 16'd0) begin
            n_fail++;
            $display("FAIL first_fetch: got %h want %h", obs_st, exp_st());
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 2; i++) begin
            #1;
            n_tests++;
            if (obs_cb !== exp_cb()) begin
                n_fail++;
                $display("FAIL seq_comb[%0d]: got %h want %h", i, obs_cb, exp_cb());
            end
            tick();
            n_tests++;
            if (obs_st !== exp_st() || pc_a !== 32'(4 * i) || ret_a !== 16'(i)) begin
                n_fail++;
                $display("FAIL seq_step[%0d]: got %h want %h", i, obs_st, exp_st());
            end
        end
    endtask

    task automatic test_branch();
        bit         brs [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit         bnes [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bit         zs [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit         tks [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] offs [4] = '{8'hFE, 8'hFE, 8'h03, 8'h03};
        int         pcs [4]  = '{4, 12, 24, 12};
        for (int i = 0; i < 4; i++) begin
            restart(3);
            BRANCH    = brs[i];
            BRANCH_NE = bnes[i];
            ZERO      = zs[i];
            OFFSET    = offs[i];
            #1;
            n_tests++;
            if (obs_cb !== exp_cb() || tk_a !== tks[i]) begin
                n_fail++;
                $display("FAIL branch_taken[%0d]: got %h want %h", i, obs_cb, exp_cb());
            end
            tick();
            n_tests++;
            if (obs_st !== exp_st() || pc_a !== 32'(pcs[i])) begin
                n_fail++;
                $display("FAIL branch_pc[%0d]: got %h want %h", i, obs_st, exp_st());
            end
        end
    endtask

    task automatic test_stall();
        restart(5);
        BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            JUMP   = ~JUMP;
            OFFSET = 8'($urandom);
            tick();
            n_tests++;
            if (obs_st !== exp_st() || pc_a !== 32'd16 || ret_a !== 16'd4) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_st, exp_st());
            end
        end
        BUSYWAIT = 1'b0;
        JUMP     = 1'b1;
        OFFSET   = 8'd1;
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd24 || ret_a !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_release: got %h want %h", obs_st, exp_st());
        end
    endtask

    task automatic test_illegal();
        restart(1);
        JUMP   = 1'b1;
        BRANCH = 1'b1;
        ZERO   = 1'($urandom);
        OFFSET = 8'd5;
        #1;
        n_tests++;
        if (obs_cb !== exp_cb() || tk_a !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_taken: got %h want %h", obs_cb, exp_cb());
        end
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd4 || err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err: got %h want %h", obs_st, exp_st());
        end
        idle_inputs();
        repeat (2) tick();
        BUSYWAIT = 1'b1;
        tick();
        n_tests++;
        if (obs_st !== exp_st() || err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky: got %h want %h", obs_st, exp_st());
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd0 || err_a !== 1'b0 || pv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h want %h", obs_st, exp_st());
        end
    endtask

    task automatic test_wrap_sat();
        restart(0);
        for (int i = 1; i <= 21; i++) begin
            tick();
            n_tests++;
            if (obs_st !== exp_st()) begin
                n_fail++;
                $display("FAIL wrap_step[%0d]: got %h want %h", i, obs_st, exp_st());
            end
            if (i == 4) begin
                n_tests++;
                if (pc_b !== 8'h00) begin
                    n_fail++;
                    $display("FAIL pc_wrap: got %h want 00", pc_b);
                end
            end
        end
        n_tests++;
        if (ret_b !== 4'd15 || ret_a !== 16'd20) begin
            n_fail++;
            $display("FAIL retired_sat: got %0d/%0d want 15/20", ret_b, ret_a);
        end
    endtask

`ifdef PC_UNIT_RAS_EN
    task automatic test_ras();
        restart(1);
        CALL   = 1'b1;
        OFFSET = 8'd4;
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd20) begin
            n_fail++;
            $display("FAIL ras_call: got %h want %h", obs_st, exp_st());
        end
        CALL = 1'b0;
        RET  = 1'b1;
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd4) begin
            n_fail++;
            $display("FAIL ras_ret: got %h want %h", obs_st, exp_st());
        end
        tick();
        n_tests++;
        if (obs_st !== exp_st() || pc_a !== 32'd8 || err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ras_empty_ret: got %h want %h", obs_st, exp_st());
        end
        RET = 1'b0;
    endtask
`endif

    task automatic test_random();
        restart(1);
        for (int i = 0; i < 400; i++) begin
            RESET     = ($urandom_range(0, 39) == 0);
            BUSYWAIT  = ($urandom_range(0, 3) == 0);
            JUMP      = ($urandom_range(0, 4) == 0);
            BRANCH    = ($urandom_range(0, 3) == 0);
            BRANCH_NE = ($urandom_range(0, 3) == 0);
            ZERO      = 1'($urandom);
            OFFSET    = 8'($urandom);
`ifdef PC_UNIT_RAS_EN
            CALL = ($urandom_range(0, 5) == 0);
            RET  = ($urandom_range(0, 5) == 0);
`endif
            #1;
            n_tests++;
            if (obs_cb !== exp_cb()) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got %h want %h", i, obs_cb, exp_cb());
            end
            tick();
            n_tests++;
            if (obs_st !== exp_st()) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got %h want %h", i, obs_st, exp_st());
            end
        end
        RESET = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RESET   = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_illegal();
        test_wrap_sat();
`ifdef PC_UNIT_RAS_EN
        test_ras();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
